// File: rtl/dmi_core_req_ctrl_pkg.sv
// Shared DMI request-controller types and constants.
// Package dmi_pkg is imported by dmi_core_req_ctrl and dmi_req_timeout_cnt.
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dmi_state_e;

    localparam logic [1:0] DMI_OP_OK     = 2'd0;
    localparam logic [1:0] DMI_OP_FAILED = 2'd2;
    localparam logic [1:0] DMI_OP_BUSY   = 2'd3;

    // First error wins; a failure outranks an overrun raised in the same cycle.
    function automatic logic [1:0] dmi_op_merge(input logic [1:0] cur,
                                                input logic       fail,
                                                input logic       overrun);
        logic [1:0] res;
        if (cur != DMI_OP_OK) begin
            res = cur;
        end else if (fail) begin
            res = DMI_OP_FAILED;
        end else if (overrun) begin
            res = DMI_OP_BUSY;
        end else begin
            res = DMI_OP_OK;
        end
        return res;
    endfunction

endpackage

// File: rtl/dmi_core_req_ctrl_timeout_cnt.sv
// WAIT-state response timeout: counter plus expiry compare.
// Instantiated by dmi_core_req_ctrl only when DMI_REQ_TIMEOUT_EN is defined.
module dmi_req_timeout_cnt
    import dmi_pkg::*;
#(
    parameter int TO_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_wait,
    output logic expire
);

    localparam int              CNT_W = $clog2(TO_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TO_CYCLES - 2);

    logic [CNT_W-1:0] cnt_r;

    // Counter is zero on WAIT entry and advances once per WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (in_wait) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Counter reaches TO_CYCLES-1 at the edge that ends this WAIT cycle.
    assign expire = in_wait && (cnt_r == LAST);

endmodule

// File: rtl/dmi_core_req_ctrl.sv
// Core-clock DMI request sequencer: strobe -> valid/ready request -> response wait.
// Optional response timeout enabled by defining DMI_REQ_TIMEOUT_EN.
module dmi_core_req_ctrl
    import dmi_pkg::*;
#(
    parameter int ADDR_W    = DMI_ADDR_W,
    parameter int DATA_W    = DMI_DATA_W,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_en,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic              sticky_clr,
    output logic              dmi_req_valid,
    output logic              dmi_req_write,
    output logic [ADDR_W-1:0] dmi_req_addr,
    output logic [DATA_W-1:0] dmi_req_wdata,
    input  logic              dmi_req_ready,
    input  logic              dmi_rsp_valid,
    input  logic              dmi_rsp_err,
    input  logic [DATA_W-1:0] dmi_rsp_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [1:0]        op_status
);

    dmi_state_e        state_r, state_s;
    logic              accept_s, complete_s, timeout_s, overrun_s, fail_s, to_expire_s;
    logic [1:0]        status_base_s, op_status_s, op_status_r;
    logic              req_valid_r, req_write_r, busy_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [DATA_W-1:0] req_wdata_r, rd_data_r;

`ifdef DMI_REQ_TIMEOUT_EN
    dmi_req_timeout_cnt #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_wait (state_r == WAIT),
        .expire  (to_expire_s)
    );
`else
    assign to_expire_s = 1'b0;
    // TO_CYCLES only sizes the timeout counter; nothing to build without it.
    if (TO_CYCLES < 2) begin : g_to_cycles_unused
    end
`endif

    // Next-state and transaction event decode.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (reg_en && ((op_status_r == DMI_OP_OK) || sticky_clr)) begin
                    accept_s = 1'b1;
                    state_s  = REQ;
                end else begin
                    state_s  = IDLE;
                end
            end
            REQ: begin
                if (dmi_req_ready && dmi_rsp_valid) begin
                    complete_s = 1'b1;
                    state_s    = IDLE;
                end else if (dmi_req_ready) begin
                    state_s    = WAIT;
                end else begin
                    state_s    = REQ;
                end
            end
            WAIT: begin
                if (dmi_rsp_valid) begin
                    complete_s = 1'b1;
                    state_s    = IDLE;
                end else if (to_expire_s) begin
                    timeout_s  = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s    = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign overrun_s     = reg_en && (state_r != IDLE);
    assign fail_s        = (complete_s && dmi_rsp_err) || timeout_s;
    assign status_base_s = sticky_clr ? DMI_OP_OK : op_status_r;
    assign op_status_s   = dmi_op_merge(status_base_s, fail_s, overrun_s);

    // State, registered outputs, request capture and read-data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            req_valid_r <= 1'b0;
            req_write_r <= 1'b0;
            req_addr_r  <= '0;
            req_wdata_r <= '0;
            rd_data_r   <= '0;
            op_status_r <= DMI_OP_OK;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            req_valid_r <= (state_s == REQ);
            op_status_r <= op_status_s;
            if (accept_s) begin
                req_write_r <= reg_wr_en;
                req_addr_r  <= reg_addr;
                req_wdata_r <= reg_wdata;
            end
            if (complete_s && !dmi_rsp_err && !req_write_r) begin
                rd_data_r <= dmi_rsp_rdata;
            end
        end
    end

    assign dmi_req_valid = req_valid_r;
    assign dmi_req_write = req_write_r;
    assign dmi_req_addr  = req_addr_r;
    assign dmi_req_wdata = req_wdata_r;
    assign rd_data       = rd_data_r;
    assign busy          = busy_r;
    assign op_status     = op_status_r;

endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// Self-checking bench for dmi_core_req_ctrl: directed scenarios plus random traffic
// against a transaction-level model. Define DMI_REQ_TIMEOUT_EN to cover the timeout.
module tb_dmi_core_req_ctrl;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reg_en = 1'b0, reg_wr_en = 1'b0, sticky_clr = 1'b0;
    logic [AW-1:0] reg_addr = '0;
    logic [DW-1:0] reg_wdata = '0;
    logic          dmi_req_ready = 1'b0, dmi_rsp_valid = 1'b0, dmi_rsp_err = 1'b0;
    logic [DW-1:0] dmi_rsp_rdata = '0;
    logic          dmi_req_valid, dmi_req_write, busy;
    logic [AW-1:0] dmi_req_addr;
    logic [DW-1:0] dmi_req_wdata, rd_data;
    logic [1:0]    op_status;

    int total = 0;
    int bad   = 0;

    dmi_core_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .reg_en(reg_en), .reg_wr_en(reg_wr_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .sticky_clr(sticky_clr),
        .dmi_req_valid(dmi_req_valid), .dmi_req_write(dmi_req_write),
        .dmi_req_addr(dmi_req_addr), .dmi_req_wdata(dmi_req_wdata),
        .dmi_req_ready(dmi_req_ready), .dmi_rsp_valid(dmi_rsp_valid),
        .dmi_rsp_err(dmi_rsp_err), .dmi_rsp_rdata(dmi_rsp_rdata),
        .rd_data(rd_data), .busy(busy), .op_status(op_status)
    );

    always #5 clk = ~clk;

    // Transaction-level view: is something in flight, has the DM taken it, what did we ask.
    typedef struct packed {
        logic          inflight;
        logic          accepted;
        logic [31:0]   wait_n;
        logic [1:0]    status;
        logic [DW-1:0] rd;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t cur, logic en, logic wr, logic [AW-1:0] a,
                                  logic [DW-1:0] wd, logic clr, logic rdy, logic rv,
                                  logic re, logic [DW-1:0] rdat);
        mdl_t       n = cur;
        logic       fail = 1'b0, over = 1'b0, done = 1'b0;
        logic [1:0] st;
        if (!cur.inflight) begin
            if (en && (cur.status == 2'd0 || clr)) begin
                n.inflight = 1'b1; n.accepted = 1'b0;
                n.write = wr; n.addr = a; n.wdata = wd;
            end
        end else begin
            over = en;
            if (!cur.accepted) begin
                if (rdy && rv) done = 1'b1;
                else if (rdy) begin n.accepted = 1'b1; n.wait_n = 32'd0; end
            end else begin
                n.wait_n = cur.wait_n + 32'd1;
                if (rv) done = 1'b1;
`ifdef DMI_REQ_TIMEOUT_EN
                else if (n.wait_n == 32'(TO - 1)) begin fail = 1'b1; n.inflight = 1'b0; end
`endif
            end
            if (done) begin
                n.inflight = 1'b0;
                if (re) fail = 1'b1;
                else if (!cur.write) n.rd = rdat;
            end
        end
        st = clr ? 2'd0 : cur.status;
        if (st == 2'd0) begin
            if (fail) st = 2'd2;
            else if (over) st = 2'd3;
        end
        n.status = st;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, reg_en, reg_wr_en, reg_addr, reg_wdata, sticky_clr,
                       dmi_req_ready, dmi_rsp_valid, dmi_rsp_err, dmi_rsp_rdata);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req_valid", 32'(dmi_req_valid), 32'(m.inflight && !m.accepted));
        chk("busy",      32'(busy),          32'(m.inflight));
        chk("req_write", 32'(dmi_req_write), 32'(m.write));
        chk("req_addr",  32'(dmi_req_addr),  32'(m.addr));
        chk("req_wdata", dmi_req_wdata,      m.wdata);
        chk("rd_data",   rd_data,            m.rd);
        chk("op_status", 32'(op_status),     32'(m.status));
    endtask

    // One clock: inputs settle, edge, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet();
        reg_en = 1'b0; reg_wr_en = 1'b0; sticky_clr = 1'b0;
        dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0;
    endtask

    task automatic strobe(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        reg_en = 1'b1; reg_wr_en = wr; reg_addr = a; reg_wdata = wd;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy",   32'(busy),      32'd0);
        chk("reset_status", 32'(op_status), 32'd0);
        chk("reset_rd",     rd_data,        32'd0);
        chk("reset_valid",  32'(dmi_req_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Read 0x11: ready on the second cycle, response three cycles later.
        strobe(1'b0, 7'h11, 32'd0); tick(); quiet();
        chk("rd_valid_1", 32'(dmi_req_valid), 32'd1);
        chk("rd_busy_1",  32'(busy),          32'd1);
        chk("rd_addr",    32'(dmi_req_addr),  32'h11);
        dmi_req_ready = 1'b1; tick(); quiet();
        chk("rd_wait_valid", 32'(dmi_req_valid), 32'd0);
        tick(); tick();
        dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'hDEADBEEF; tick(); quiet();
        chk("rd_data",   rd_data,             32'hDEADBEEF);
        chk("rd_busy_0", 32'(busy),           32'd0);
        chk("rd_status", 32'(op_status),      32'd0);

        // Write 0x10 <- 1 with ready held low for 5 cycles.
        strobe(1'b1, 7'h10, 32'h1); tick(); quiet();
        reg_addr = 7'h55; reg_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wr_valid_hold", 32'(dmi_req_valid), 32'd1);
            chk("wr_addr_hold",  32'(dmi_req_addr),  32'h10);
            chk("wr_data_hold",  dmi_req_wdata,      32'h1);
            chk("wr_write_hold", 32'(dmi_req_write), 32'd1);
        end
        dmi_req_ready = 1'b1; tick(); quiet();
        dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h1234_5678; tick(); quiet();
        chk("wr_rd_keep", rd_data, 32'hDEADBEEF);

        // Overrun while in WAIT, then drop until sticky_clr.
        strobe(1'b0, 7'h02, 32'd0); tick(); quiet();
        dmi_req_ready = 1'b1; tick(); quiet();
        strobe(1'b0, 7'h03, 32'd0); tick(); quiet();
        chk("ovr_status", 32'(op_status), 32'd3);
        chk("ovr_busy",   32'(busy),      32'd1);
        dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'hCAFEF00D; tick(); quiet();
        chk("ovr_rd",     rd_data,        32'hCAFEF00D);
        chk("ovr_status_hold", 32'(op_status), 32'd3);
        strobe(1'b0, 7'h04, 32'd0); tick(); quiet();
        chk("ovr_drop", 32'(busy), 32'd0);
        strobe(1'b0, 7'h05, 32'd0); sticky_clr = 1'b1; tick(); quiet();
        chk("clr_accept", 32'(busy),      32'd1);
        chk("clr_status", 32'(op_status), 32'd0);

        // Same-cycle ready + response from REQ.
        dmi_req_ready = 1'b1; dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h0BAD_F00D; tick(); quiet();
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_rd",   rd_data,   32'h0BAD_F00D);

        // Error response on a read, then a refused request keeps status 2.
        strobe(1'b0, 7'h06, 32'd0); tick(); quiet();
        dmi_req_ready = 1'b1; tick(); quiet();
        dmi_rsp_valid = 1'b1; dmi_rsp_err = 1'b1; dmi_rsp_rdata = 32'h5555_AAAA; tick(); quiet();
        chk("err_status", 32'(op_status), 32'd2);
        chk("err_rd",     rd_data,        32'h0BAD_F00D);
        strobe(1'b0, 7'h07, 32'd0); tick(); quiet();
        chk("err_keep", 32'(op_status), 32'd2);

`ifdef DMI_REQ_TIMEOUT_EN
        sticky_clr = 1'b1; tick(); quiet();
        strobe(1'b0, 7'h08, 32'd0); tick(); quiet();
        dmi_req_ready = 1'b1; tick(); quiet();
        repeat (6) tick();
        chk("to_still_busy", 32'(busy), 32'd1);
        tick();
        chk("to_idle",   32'(busy),      32'd0);
        chk("to_status", 32'(op_status), 32'd2);
        dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h7777_7777; tick(); quiet();
        chk("to_late_rd", rd_data, 32'h0BAD_F00D);
`endif

        // Random traffic against the model, with one asynchronous reset mid-run.
        for (int c = 0; c < 4000; c++) begin
            reg_en        = ($urandom_range(0, 5) == 0);
            reg_wr_en     = 1'($urandom_range(0, 1));
            reg_addr      = 7'($urandom);
            reg_wdata     = $urandom;
            sticky_clr    = ($urandom_range(0, 19) == 0);
            dmi_req_ready = 1'($urandom_range(0, 1));
            dmi_rsp_valid = ($urandom_range(0, 3) == 0);
            dmi_rsp_err   = ($urandom_range(0, 4) == 0);
            dmi_rsp_rdata = $urandom;
            if (c == 2000) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_busy",   32'(busy),      32'd0);
                chk("async_valid",  32'(dmi_req_valid), 32'd0);
                chk("async_rd",     rd_data,        32'd0);
                chk("async_status", 32'(op_status), 32'd0);
                #1 rst_n = 1'b1;
            end
            tick();
        end

        quiet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmi_core_req_ctrl.md
Name: dmi_core_req_ctrl

Overview:
Core-clock sequencer between the JTAG-to-core DMI synchronizer and the debug module register interface. Converts single-cycle synchronized read/write strobes into a valid/ready request plus a response wait. Holds read data and a sticky DMI op status for the JTAG side to sample. Enforces one outstanding transaction and records overrun, error and (optionally) timeout.

Parameters:
ADDR_W, 7, DMI address width
DATA_W, 32, DMI data width
TO_CYCLES, 1024, response timeout in clk cycles (used only with the optional feature); must be >= 2

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
reg_en  in  1  1-cycle strobe from synchronizer, read or write request
reg_wr_en  in  1  1-cycle strobe, qualifies reg_en as write
reg_addr  in  ADDR_W  quasi-static JTAG address, stable while strobe pending
reg_wdata  in  DATA_W  quasi-static JTAG write data
sticky_clr  in  1  1-cycle synchronized dmireset strobe
dmi_req_valid  out  1  request valid to debug module
dmi_req_write  out  1  1 = write, 0 = read
dmi_req_addr  out  ADDR_W  request address
dmi_req_wdata  out  DATA_W  request write data
dmi_req_ready  in  1  debug module accepts request
dmi_rsp_valid  in  1  1-cycle response strobe
dmi_rsp_err  in  1  response error, qualified by dmi_rsp_valid
dmi_rsp_rdata  in  DATA_W  read data, qualified by dmi_rsp_valid
rd_data  out  DATA_W  last successful read data, held
busy  out  1  transaction in flight
op_status  out  2  0 = ok, 2 = failed, 3 = busy/overrun (sticky)

Behaviour:
- Reset: state IDLE; all outputs 0; request registers cleared.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - reg_en=1 and op_status==0: capture reg_wr_en, reg_addr and reg_wdata into request registers; go to REQ next cycle.
  - dmi_req_valid asserts 1 cycle after the strobe.
  - reg_en=1 and op_status!=0: request dropped; no state change.
- REQ:
  - dmi_req_valid=1; request fields held stable until dmi_req_ready.
  - ready=1 and rsp_valid=0: go to WAIT.
  - ready=1 and rsp_valid=1 in the same cycle: complete directly, return to IDLE.
- WAIT: dmi_req_valid=0; rsp_valid=1 completes and returns to IDLE.
- Completion:
  - rsp_err=1: op_status set to 2 if currently 0; rd_data unchanged.
  - rsp_err=0 and read: rd_data <= dmi_rsp_rdata.
  - Write completion never alters rd_data.
- busy = (state != IDLE), registered, so busy=1 the cycle after the accepted strobe.
- reg_en=1 while busy: request dropped; op_status set to 3 if currently 0 (overrun); in-flight transaction unaffected.
- op_status:
  - First error wins; later errors do not overwrite.
  - sticky_clr forces 0.
  - sticky_clr and a new error in the same cycle: the error wins.
  - sticky_clr and reg_en in the same IDLE cycle: clear applies and the request is accepted.
- sticky_clr does not abort an in-flight transaction.
- rsp_valid outside REQ/WAIT is ignored.
- Async reset mid-transaction returns to IDLE immediately; the debug module must also be reset by the same rst_n.
- reg_wr_en without reg_en is ignored.

Optional Feature:
Macro DMI_REQ_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT and increments each cycle in WAIT.
  - Reaching TO_CYCLES-1 without rsp_valid: return to IDLE, set op_status=2 if 0, rd_data unchanged.
  - Response in the same cycle as expiry: the response wins.
  - Counter width is clog2(TO_CYCLES).
- Undefined: no counter; WAIT persists until rsp_valid.

Decomposition:
- Package dmi_pkg:
  - DMI_ADDR_W=7, DMI_DATA_W=32.
  - FSM state enum (IDLE/REQ/WAIT).
  - op status constants DMI_OP_OK=0, DMI_OP_FAILED=2, DMI_OP_BUSY=3.
- Sub-module dmi_req_timeout_cnt (counter plus expiry compare), instantiated only under DMI_REQ_TIMEOUT_EN.

Test Plan:
- Read: reg_en=1, wr_en=0, addr=0x11; ready=1 on cycle 2; rsp_valid with rdata=0xDEADBEEF 3 cycles later -> rd_data=0xDEADBEEF, busy back to 0, op_status=0.
- Write: reg_en+reg_wr_en, addr=0x10, wdata=0x1; ready held 0 for 5 cycles -> req_valid/addr/wdata stable throughout; after completion rd_data is unchanged.
- Overrun: second reg_en while in WAIT -> op_status=3; first transaction completes normally; later reg_en is ignored until sticky_clr, then accepted.
- Error: rsp_err=1 on a read -> op_status=2 and rd_data unchanged; a subsequent overrun keeps status at 2.
- Same-cycle completion: ready=1 and rsp_valid=1 in the REQ cycle -> IDLE next cycle with data captured.
- With DMI_REQ_TIMEOUT_EN, TO_CYCLES=8: no response -> IDLE after 7 WAIT cycles with op_status=2; a late rsp_valid is ignored.
